data_pack: RTL
==============

Name: data_pack

Overview:
Packs a stream of 7-bit symbols into 32-bit words. It is the transmit-side counterpart of the 32-to-7 unpacker and uses the same bit mapping. Symbol k of a packet occupies stream bits [7k+6:7k]. Word w carries stream bits [32w+31:32w]. Both sides are LSB-first, and symbols straddle word boundaries, so 32 symbols fill exactly 7 words. The block sits between the symbol source and the 32-bit link or FIFO, with ready/valid handshakes on both sides.

Parameters:
SYM_W, 7, input symbol width in bits; must satisfy 1 <= SYM_W < WORD_W.
WORD_W, 32, output word width in bits.

Ports:
clk  input  1  clock, rising edge
rst  input  1  reset, asynchronous, active-low
valid_in  input  1  data_in/sop_in/eop_in valid
ready_out  output  1  block accepts a symbol this cycle
data_in  input  SYM_W  input symbol
sop_in  input  1  first symbol of packet
eop_in  input  1  last symbol of packet
valid_out  output  1  output word valid
ready_in  input  1  downstream accepts the word
data_out  output  WORD_W  packed word, unused upper bits zero
sop_out  output  1  first word of packet
eop_out  output  1  last word of packet
last_bits_out  output  6  number of valid bits in data_out (1..32); 32 on all words except a short final word
err_out  output  1  one-cycle pulse on a protocol error

Behaviour:
- Reset: one clock, clk; rst is asynchronous and active-low. Assertion immediately clears all state. Outputs go to: valid_out=0, data_out=0, sop_out=0, eop_out=0, last_bits_out=0, err_out=0. The FSM enters IDLE, and the accumulator and fill count cnt go to 0. Reset mid-packet discards all partial data, and a word held on the output is dropped.
- Accept: a symbol is accepted when valid_in & ready_out.
- ready_out = (state != FLUSH) & (!valid_out | ready_in). The output register can therefore be reloaded in the same cycle it drains. With ready_in=1, throughput is 1 symbol/clk.
- Accumulator: 38 bits (WORD_W+SYM_W-1); cnt ranges 0..31 between accepts.
  - On accept: acc |= data_in << cnt, then cnt += 7.
  - If the new cnt >= 32: load the low 32 bits into data_out, shift acc right by 32, and set cnt -= 32.
- Output register: loaded on the clock edge of the completing accept, so latency is 1 clk. data_out, sop_out, eop_out and last_bits_out are held stable while valid_out & !ready_in. valid_out clears after a handshake unless a new word is loaded on the same edge.
- sop_out: asserted on the first word of a packet, tracked by a flag set on an accept with sop_in.
- FSM states:
  - IDLE: no packet is open. An accept with sop_in moves to ACCUM, or handles the symbol as EOP when eop_in is also set. An accept without sop_in drops the symbol, pulses err_out, and stays in IDLE.
  - ACCUM: packing is in progress. An accept with eop_in is handled as EOP.
  - FLUSH: a remainder word is pending. ready_out is 0. When the output register is free, the block emits the zero-padded remainder with eop_out=1 and last_bits_out=cnt, clears acc and cnt, and goes to IDLE.
- EOP handling (accept with eop_in):
  - New cnt < 32: emit the zero-padded word immediately with eop_out=1 and last_bits_out=cnt, then go to IDLE.
  - New cnt == 32: emit the full word with eop_out=1 and last_bits_out=32, then go to IDLE.
  - New cnt > 32: emit the full word with eop_out=0, then go to FLUSH with the remainder.
- sop_in while in ACCUM:
  - Pulse err_out.
  - Discard the partial acc; words already emitted stand.
  - Restart packing from bit 0 with this symbol as symbol 0 of a new packet.
- sop_in and eop_in together on one symbol: forms a single-word packet with sop_out=eop_out=1 and last_bits_out=7.
- valid_in while ready_out=0: the symbol is not accepted. The source must hold it stable until accepted.

Test Plan:
1. Packet of 32 symbols, symbol k = k, ready_in=1 -> 7 words, back-to-back accepts, no FLUSH.
   - word0 = 0x40608080 with sop_out=1.
   - word6 has eop_out=1.
   - All last_bits_out = 32.
2. Single symbol 0x55 with sop_in=eop_in=1 -> one word 0x00000055 with sop_out=eop_out=1, last_bits_out=7.
3. Five symbols 0x7F, eop_in on the 5th -> word 0xFFFFFFFF (sop_out=1, last_bits_out=32), then ready_out=0 for one cycle (FLUSH), then word 0x00000007 with eop_out=1 and last_bits_out=3.
4. Backpressure: ready_in=0 for 10 clk while a word is pending -> valid_out stays 1, data_out is stable, ready_out=0. On release, all symbols are packed with none lost or duplicated; the scoreboard matches the unpacker's mapping.
5. Protocol errors:
   - Symbol without sop_in in IDLE -> dropped, err_out pulses 1 clk.
   - sop_in after 3 symbols -> err_out pulses; the next word contains only the new packet's symbols starting at bit 0.
6. rst asserted mid-packet, asynchronously between clock edges -> valid_out falls immediately. After release, a new sop packet packs from bit 0 with correct words.

Source files
------------

// File: rtl/data_pack_if.sv
// Symbol-in / word-out stream bundle for data_pack.
// slave faces the packer; master faces the symbol source and word sink.
interface data_pack_if #(
   parameter int SYM_W  = 7,
   parameter int WORD_W = 32
);
   logic              valid_in;
   logic              ready_out;
   logic [SYM_W-1:0]  data_in;
   logic              sop_in;
   logic              eop_in;
   logic              valid_out;
   logic              ready_in;
   logic [WORD_W-1:0] data_out;
   logic              sop_out;
   logic              eop_out;
   logic [5:0]        last_bits_out;
   logic              err_out;

   modport slave (
      input  valid_in, data_in, sop_in, eop_in, ready_in,
      output ready_out, valid_out, data_out, sop_out, eop_out, last_bits_out, err_out
   );

   modport master (
      output valid_in, data_in, sop_in, eop_in, ready_in,
      input  ready_out, valid_out, data_out, sop_out, eop_out, last_bits_out, err_out
   );
endinterface

// File: rtl/data_pack.sv
// Packs SYM_W-bit symbols LSB-first into WORD_W-bit words.
// Symbols straddle word boundaries; a short final word is zero-padded.
module data_pack #(
   parameter int SYM_W  = 7,
   parameter int WORD_W = 32
) (
   input logic        clk,
   input logic        rst,
   data_pack_if.slave bus
);
   localparam int ACC_W = WORD_W + SYM_W - 1;
   localparam int CNT_W = $clog2(WORD_W + SYM_W);
   localparam logic [CNT_W-1:0] WORD_CNT = CNT_W'(WORD_W);
   localparam logic [CNT_W-1:0] SYM_CNT  = CNT_W'(SYM_W);

   typedef enum logic [1:0] {IDLE, ACCUM, FLUSH} state_t;

   state_t             state_q, state_d;
   logic [ACC_W-1:0]   acc_q, acc_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic               first_q, first_d;
   logic               vout_q, vout_d;
   logic [WORD_W-1:0]  dout_q, dout_d;
   logic               sop_q, sop_d;
   logic               eop_q, eop_d;
   logic [5:0]         last_q, last_d;
   logic               err_q, err_d;

   logic               out_free, accept, take, base_first;
   logic [ACC_W-1:0]   base_acc, sum;
   logic [CNT_W-1:0]   base_cnt, ncnt;

   // The output register may reload on the same edge it drains.
   assign out_free      = !vout_q || bus.ready_in;
   assign bus.ready_out = (state_q != FLUSH) && out_free;
   assign accept        = bus.valid_in && bus.ready_out;

   assign bus.valid_out     = vout_q;
   assign bus.data_out      = dout_q;
   assign bus.sop_out       = sop_q;
   assign bus.eop_out       = eop_q;
   assign bus.last_bits_out = last_q;
   assign bus.err_out       = err_q;

   always_comb begin
      state_d    = state_q;
      acc_d      = acc_q;
      cnt_d      = cnt_q;
      first_d    = first_q;
      vout_d     = vout_q && !bus.ready_in;
      dout_d     = dout_q;
      sop_d      = sop_q;
      eop_d      = eop_q;
      last_d     = last_q;
      err_d      = 1'b0;
      take       = 1'b0;
      base_acc   = acc_q;
      base_cnt   = cnt_q;
      base_first = first_q;
      sum        = '0;
      ncnt       = '0;

      if (accept) begin
         if (state_q == IDLE && !bus.sop_in) begin
            err_d = 1'b1;
         end else begin
            take = 1'b1;
            // sop always restarts at bit 0; mid-packet it also flags an error.
            if (bus.sop_in) begin
               base_acc   = '0;
               base_cnt   = '0;
               base_first = 1'b1;
               err_d      = (state_q == ACCUM);
            end
         end
      end

      if (take) begin
         sum     = base_acc | (ACC_W'(bus.data_in) << base_cnt);
         ncnt    = base_cnt + SYM_CNT;
         state_d = ACCUM;
         acc_d   = sum;
         cnt_d   = ncnt;
         first_d = base_first;
         if (ncnt >= WORD_CNT) begin
            vout_d  = 1'b1;
            dout_d  = sum[WORD_W-1:0];
            sop_d   = base_first;
            eop_d   = 1'b0;
            last_d  = 6'(WORD_W);
            first_d = 1'b0;
            acc_d   = sum >> WORD_W;
            cnt_d   = ncnt - WORD_CNT;
            if (bus.eop_in) begin
               if (ncnt == WORD_CNT) begin
                  eop_d   = 1'b1;
                  state_d = IDLE;
               end else begin
                  state_d = FLUSH;
               end
            end
         end else if (bus.eop_in) begin
            vout_d  = 1'b1;
            dout_d  = sum[WORD_W-1:0];
            sop_d   = base_first;
            eop_d   = 1'b1;
            last_d  = 6'(ncnt);
            first_d = 1'b0;
            acc_d   = '0;
            cnt_d   = '0;
            state_d = IDLE;
         end
      end

      if (state_q == FLUSH && out_free) begin
         vout_d  = 1'b1;
         dout_d  = acc_q[WORD_W-1:0];
         sop_d   = 1'b0;
         eop_d   = 1'b1;
         last_d  = 6'(cnt_q);
         acc_d   = '0;
         cnt_d   = '0;
         state_d = IDLE;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= IDLE;
         acc_q   <= '0;
         cnt_q   <= '0;
         first_q <= 1'b0;
         vout_q  <= 1'b0;
         dout_q  <= '0;
         sop_q   <= 1'b0;
         eop_q   <= 1'b0;
         last_q  <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         acc_q   <= acc_d;
         cnt_q   <= cnt_d;
         first_q <= first_d;
         vout_q  <= vout_d;
         dout_q  <= dout_d;
         sop_q   <= sop_d;
         eop_q   <= eop_d;
         last_q  <= last_d;
         err_q   <= err_d;
      end
   end
endmodule
